// File: rtl/alu_result_sel_if.sv
// Handshake bundle between functional units, issuer and the result-select stage.
// master drives requests and unit data; slave is the select stage.
interface alu_result_sel_if #(
  parameter int N   = 32,
  parameter int CH  = 8,
  parameter int OPW = 4
);
  logic [CH*N-1:0] x_flat;
  logic [CH-1:0]   x_done;
  logic            start;
  logic [OPW-1:0]  opcode;
  logic            busy;
  logic [N-1:0]    out;
  logic            out_valid;
  logic            err;

  modport master (
    output x_flat, x_done, start, opcode,
    input  busy, out, out_valid, err
  );

  modport slave (
    input  x_flat, x_done, start, opcode,
    output busy, out, out_valid, err
  );
endinterface

// File: rtl/alu_result_sel.sv
// Registered ALU result select: waits for the chosen unit's done strobe,
// then registers its data with a one-cycle valid, or flags illegal/timeout.
module alu_result_sel #(
  parameter int N       = 32,
  parameter int CH      = 8,
  parameter int OPW     = 4,
  parameter int TIMEOUT = 15
) (
  input logic            clk,
  input logic            rst,
  alu_result_sel_if.slave bus
);
  localparam int SW = $clog2(CH);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state;
  logic [SW-1:0] sel;
  logic [CW-1:0] cnt;
  logic [N-1:0]  xs [CH];
  logic          legal;
  logic [SW-1:0] map;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign xs[i] = bus.x_flat[i*N +: N];
  end

  // opcode 0 names the last channel; k names channel k-1
  assign legal = {1'b0, bus.opcode} < (OPW+1)'(CH);
  assign map   = (bus.opcode == '0) ? SW'(CH - 1)
                                    : SW'(bus.opcode - 1'b1);

  assign bus.busy = (state == WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      sel           <= '0;
      cnt           <= '0;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.err       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (legal) begin
              sel   <= map;
              cnt   <= '0;
              state <= WAIT;
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        WAIT: begin
          // done wins over timeout in the last wait cycle
          if (bus.x_done[sel]) begin
            bus.out       <= xs[sel];
            bus.out_valid <= 1'b1;
            state         <= IDLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            bus.err <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_result_sel.md
# alu_result_sel

Registered, parametrised result-select stage for the ALU datapath. It generalises the opcode-driven result mux to CH functional-unit channels of N bits. It waits for the selected unit's completion strobe, which allows multi-cycle units such as a multiplier or divider, then registers the result with a one-cycle valid pulse. It sits between the functional units and register-file writeback and raises an error on an illegal opcode or a unit timeout.

## Interface
- N, 32, data width of every channel and of out
- CH, 8, number of functional-unit channels (2..16)
- OPW, 4, opcode width; must satisfy 2**OPW >= CH
- TIMEOUT, 15, maximum WAIT cycles before abort (>= 1)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- x_flat  in  CH*N  channel data; channel i = x_flat[(i+1)*N-1 : i*N]
- x_done  in  CH  per-channel completion strobe; data valid in the same cycle
- start  in  1  request; samples opcode
- opcode  in  OPW  result select
- busy  out  1  high while in WAIT
- out  out  N  registered result
- out_valid  out  1  one-cycle pulse when out is updated
- err  out  1  one-cycle pulse on illegal opcode or timeout

## Operation
- Opcode mapping:
  - opcode 0 -> channel CH-1
  - opcode k, 1 <= k <= CH-1 -> channel k-1
  - opcode >= CH -> illegal
- FSM states: IDLE and WAIT.
- IDLE:
  - start=1 with a legal opcode: latch the channel index into sel, clear cnt, go to WAIT.
  - start=1 with an illegal opcode: err=1 next cycle, stay in IDLE, out unchanged.
  - start=0: stay in IDLE.
- WAIT:
  - x_done[sel]=1: register out <= channel sel, out_valid=1 next cycle, go to IDLE.
  - x_done[sel]=0 and cnt == TIMEOUT-1: err=1 next cycle, out unchanged, go to IDLE.
  - Otherwise: cnt++.
- Done takes priority over timeout in the final WAIT cycle.
- x_done bits of unselected channels are ignored.
- start and opcode are ignored while busy=1. There is no queueing; the issuer must hold requests.
- cnt width is clog2(TIMEOUT+1). cnt never wraps, because the abort occurs first.
- out holds its last value indefinitely; only a completed operation or reset changes it.

## Timing
- Reset values: state IDLE, out=0, out_valid=0, err=0, busy=0, sel=0, cnt=0.
- Reset asserted mid-WAIT abandons the operation; no out_valid or err is produced for it.
- Cycle sequence for one operation:
  - start sampled at edge E0 -> busy=1 after E0.
  - x_done[sel] sampled at edge E1 or later (Ek) -> out and out_valid=1 after Ek, busy=0 after Ek.
- Minimum latency is 2 edges from start to out_valid.
- Throughput: a new start is accepted in the out_valid cycle, so at most one operation per 2 cycles.
- x_done[sel] asserted in the same cycle as start is not observed; sampling begins in the first WAIT cycle.
- Timeout: with no done, err pulses after exactly TIMEOUT WAIT cycles, i.e. TIMEOUT+1 edges after the start edge.
- An illegal opcode produces err 1 edge after start; busy stays 0.
- out_valid and err are never high in the same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then CH=8, N=32. Channel i data = 0x1000_0000+i, all x_done=1. Apply opcode 1..7 then 0, one start each, 2 cycles apart -> out = 0x1000_0000, ..0001, .., ..0006, then 0x1000_0007; each out_valid arrives 2 edges after its start.
- opcode=3 (channel 2), x_done[2] raised on the 5th WAIT cycle with data 0xDEAD_BEEF; x_done[5] pulsed earlier -> busy high for 5 cycles; out=0xDEAD_BEEF with out_valid exactly once; the channel-5 strobe has no effect.
- TIMEOUT=15, opcode=2, x_done=0 throughout -> err pulses 16 edges after start; out keeps its previous value; busy=0 afterwards. Repeat with x_done[1] raised on WAIT cycle 15 -> out_valid, no err.
- CH=6, OPW=4, opcode=9 -> err pulse 1 edge later; busy never asserts; out unchanged. A legal opcode issued the next cycle completes normally.
- start held high with opcode changing during WAIT -> only the opcode sampled at accept is used. Assert rst mid-WAIT -> all outputs 0 immediately; no out_valid or err follows after rst is released.
- Parameter sweep N=8/CH=2 and N=64/CH=16 -> the mapping for opcode 0 (channel CH-1) and for opcode CH-1 is correct, and opcode CH raises err.
